// File: rtl/qea_ctrl_loader_if.sv
// Host-side handshake bundle for qea_ctrl_loader: job command, context word
// stream in, and state-vector result stream out.
interface qea_ctrl_loader_if #(
  parameter int CTX_ADDR_W = 16,
  parameter int CTX_DATA_W = 64,
  parameter int QBIT_W     = 6,
  parameter int RD_DATA_W  = 256
);
  logic                  i_cmd_valid;
  logic                  o_cmd_ready;
  logic [CTX_ADDR_W-1:0] i_ins_num;
  logic [QBIT_W-1:0]     i_qbit_num;
  logic                  i_ctx_valid;
  logic                  o_ctx_ready;
  logic [CTX_DATA_W-1:0] i_ctx_data;
  logic                  o_rd_valid;
  logic                  i_rd_ready;
  logic [RD_DATA_W-1:0]  o_rd_data;

  modport slave (
    input  i_cmd_valid, i_ins_num, i_qbit_num, i_ctx_valid, i_ctx_data, i_rd_ready,
    output o_cmd_ready, o_ctx_ready, o_rd_valid, o_rd_data
  );

  modport master (
    output i_cmd_valid, i_ins_num, i_qbit_num, i_ctx_valid, i_ctx_data, i_rd_ready,
    input  o_cmd_ready, o_ctx_ready, o_rd_valid, o_rd_data
  );
endinterface

// File: rtl/qea_ctrl_loader.sv
// Job sequencer for the quantum emulation accelerator: loads gate context,
// initialises the state RAM to |0...0>, runs the accelerator and streams the result.
module qea_ctrl_loader #(
  parameter int PE_NUM                  = 4,
  parameter int STATE_DATA_WIDTH        = 64,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_CONTEXT_DATA_WIDTH = 64,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int MAX_QBIT_WIDTH          = 6
) (
  input  logic                                 clk,
  input  logic                                 rst,
  qea_ctrl_loader_if.slave                     host,
  output logic                                 o_qea_start,
  output logic [MAX_QBIT_WIDTH-1:0]            o_qea_qbit_num,
  input  logic                                 i_qea_complete,
  output logic                                 o_ctx_en,
  output logic                                 o_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
  output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
  output logic                                 o_state_ena,
  output logic                                 o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dout,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_err,
  output logic [31:0]                          o_cycle_count
);

  localparam int WORD_W = PE_NUM * STATE_DATA_WIDTH;
  localparam int AW1    = STATE_ADDR_WIDTH + 1;
  localparam logic [MAX_QBIT_WIDTH-1:0] QBIT_MIN = MAX_QBIT_WIDTH'(2);
  localparam logic [MAX_QBIT_WIDTH-1:0] QBIT_MAX = MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH + 2);
  // Q2.x amplitude 1.0 + 0.0i: real half starts with 2'b01, imaginary half zero
  localparam logic [STATE_DATA_WIDTH-1:0] INIT_AMP = {2'b01, {(STATE_DATA_WIDTH-2){1'b0}}};

  typedef enum logic [3:0] {
    ST_IDLE, ST_LOAD_CTX, ST_INIT_STATE, ST_START, ST_RUN,
    ST_RD_ADDR, ST_RD_WAIT, ST_RD_OUT, ST_DONE
  } state_t;

  state_t                              state_r, state_nxt_s;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]  ins_num_r, ctx_addr_r, ctx_last_s;
  logic [MAX_QBIT_WIDTH-1:0]           qbit_num_r;
  logic [STATE_ADDR_WIDTH-1:0]         st_addr_r, st_last_s;
  logic [AW1-1:0]                      n_words_s;
  logic [31:0]                         cycle_cnt_r;
  logic [WORD_W-1:0]                   rd_data_r, init_word_s;
  logic                                err_r, cmd_bad_s;
  logic                                cmd_ready_s, ctx_ready_s, ctx_we_s;
  logic                                st_ena_s, st_wea_s, rd_valid_s, start_s, done_s;

  assign cmd_bad_s  = (host.i_ins_num == {GATE_CONTEXT_ADDR_WIDTH{1'b0}})
                    | (host.i_qbit_num < QBIT_MIN) | (host.i_qbit_num > QBIT_MAX);
  assign ctx_last_s = ins_num_r - GATE_CONTEXT_ADDR_WIDTH'(1);
  assign n_words_s  = AW1'(1) << (qbit_num_r - MAX_QBIT_WIDTH'(2));
  assign st_last_s  = STATE_ADDR_WIDTH'(n_words_s - AW1'(1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and state-decoded strobes
  always_comb begin
    state_nxt_s = state_r;
    cmd_ready_s = 1'b0;
    ctx_ready_s = 1'b0;
    ctx_we_s    = 1'b0;
    st_ena_s    = 1'b0;
    st_wea_s    = 1'b0;
    rd_valid_s  = 1'b0;
    start_s     = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cmd_ready_s = 1'b1;
        if (host.i_cmd_valid && !cmd_bad_s) state_nxt_s = ST_LOAD_CTX;
        else                                state_nxt_s = ST_IDLE;
      end
      ST_LOAD_CTX: begin
        ctx_ready_s = 1'b1;
        if (host.i_ctx_valid) begin
          ctx_we_s = 1'b1;
          if (ctx_addr_r == ctx_last_s) state_nxt_s = ST_INIT_STATE;
          else                          state_nxt_s = ST_LOAD_CTX;
        end else begin
          state_nxt_s = ST_LOAD_CTX;
        end
      end
      ST_INIT_STATE: begin
        st_ena_s = 1'b1;
        st_wea_s = 1'b1;
        if (st_addr_r == st_last_s) state_nxt_s = ST_START;
        else                        state_nxt_s = ST_INIT_STATE;
      end
      ST_START: begin
        start_s     = 1'b1;
        state_nxt_s = ST_RUN;
      end
      ST_RUN: begin
        if (i_qea_complete) state_nxt_s = ST_RD_ADDR;
        else                state_nxt_s = ST_RUN;
      end
      ST_RD_ADDR: begin
        st_ena_s    = 1'b1;
        state_nxt_s = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        state_nxt_s = ST_RD_OUT;
      end
      ST_RD_OUT: begin
        rd_valid_s = 1'b1;
        if (host.i_rd_ready) begin
          if (st_addr_r == st_last_s) state_nxt_s = ST_DONE;
          else                        state_nxt_s = ST_RD_ADDR;
        end else begin
          state_nxt_s = ST_RD_OUT;
        end
      end
      ST_DONE: begin
        done_s      = 1'b1;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Job latches, address counters, run-time counter and readout register
  always_ff @(posedge clk) begin
    if (rst) begin
      ins_num_r   <= {GATE_CONTEXT_ADDR_WIDTH{1'b0}};
      qbit_num_r  <= {MAX_QBIT_WIDTH{1'b0}};
      ctx_addr_r  <= {GATE_CONTEXT_ADDR_WIDTH{1'b0}};
      st_addr_r   <= {STATE_ADDR_WIDTH{1'b0}};
      cycle_cnt_r <= 32'd0;
      rd_data_r   <= {WORD_W{1'b0}};
      err_r       <= 1'b0;
    end else begin
      err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          ctx_addr_r <= {GATE_CONTEXT_ADDR_WIDTH{1'b0}};
          st_addr_r  <= {STATE_ADDR_WIDTH{1'b0}};
          if (host.i_cmd_valid) begin
            ins_num_r  <= host.i_ins_num;
            qbit_num_r <= host.i_qbit_num;
            err_r      <= cmd_bad_s;
          end
        end
        ST_LOAD_CTX: begin
          if (host.i_ctx_valid) ctx_addr_r <= ctx_addr_r + GATE_CONTEXT_ADDR_WIDTH'(1);
        end
        ST_INIT_STATE: begin
          // wraps to 0 so the readout pass starts from the first word
          if (st_addr_r == st_last_s) st_addr_r <= {STATE_ADDR_WIDTH{1'b0}};
          else                        st_addr_r <= st_addr_r + STATE_ADDR_WIDTH'(1);
        end
        ST_START: begin
          cycle_cnt_r <= 32'd0;
        end
        ST_RUN: begin
          if (cycle_cnt_r != 32'hFFFF_FFFF) cycle_cnt_r <= cycle_cnt_r + 32'd1;
        end
        ST_RD_WAIT: begin
          rd_data_r <= i_state_dout;
        end
        ST_RD_OUT: begin
          if (host.i_rd_ready) st_addr_r <= st_addr_r + STATE_ADDR_WIDTH'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Initial state vector: amplitude 1.0 in the top lane of word 0, zero elsewhere
  always_comb begin
    init_word_s = {WORD_W{1'b0}};
    if (st_addr_r == {STATE_ADDR_WIDTH{1'b0}}) begin
      init_word_s[WORD_W-1 -: STATE_DATA_WIDTH] = INIT_AMP;
    end else begin
      init_word_s = {WORD_W{1'b0}};
    end
  end

  assign host.o_cmd_ready = cmd_ready_s;
  assign host.o_ctx_ready = ctx_ready_s;
  assign host.o_rd_valid  = rd_valid_s;
  assign host.o_rd_data   = rd_data_r;
  assign o_qea_start      = start_s;
  assign o_qea_qbit_num   = qbit_num_r;
  assign o_ctx_en         = ctx_we_s;
  assign o_ctx_wea        = ctx_we_s;
  assign o_ctx_addr       = ctx_we_s ? ctx_addr_r : {GATE_CONTEXT_ADDR_WIDTH{1'b0}};
  assign o_ctx_data       = ctx_we_s ? host.i_ctx_data : {GATE_CONTEXT_DATA_WIDTH{1'b0}};
  assign o_state_ena      = st_ena_s;
  assign o_state_wea      = st_wea_s;
  assign o_state_addra    = st_ena_s ? st_addr_r : {STATE_ADDR_WIDTH{1'b0}};
  assign o_state_dina     = st_wea_s ? init_word_s : {WORD_W{1'b0}};
  assign o_busy           = (state_r != ST_IDLE);
  assign o_done           = done_s;
  assign o_err            = err_r;
  assign o_cycle_count    = cycle_cnt_r;

endmodule

// File: tb/tb_qea_ctrl_loader.sv
// Scoreboard bench for qea_ctrl_loader: expected RAM writes and readout words
// are queued when stimulus is issued and popped as the DUT produces them.
module tb_qea_ctrl_loader;
  localparam int PE = 4, SDW = 64, SAW = 16, GCDW = 64, GCAW = 16, MQW = 6;
  localparam int W = PE * SDW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  qea_ctrl_loader_if #(.CTX_ADDR_W(GCAW), .CTX_DATA_W(GCDW), .QBIT_W(MQW), .RD_DATA_W(W)) bus ();

  logic            qea_start, qea_complete;
  logic [MQW-1:0]  qea_qbit;
  logic            ctx_en, ctx_wea;
  logic [GCAW-1:0] ctx_addr;
  logic [GCDW-1:0] ctx_data;
  logic            state_ena, state_wea;
  logic [SAW-1:0]  state_addra;
  logic [W-1:0]    state_dina, state_dout;
  logic            busy, done, err;
  logic [31:0]     cycle_count;

  qea_ctrl_loader #(
    .PE_NUM(PE), .STATE_DATA_WIDTH(SDW), .STATE_ADDR_WIDTH(SAW),
    .GATE_CONTEXT_DATA_WIDTH(GCDW), .GATE_CONTEXT_ADDR_WIDTH(GCAW), .MAX_QBIT_WIDTH(MQW)
  ) dut (
    .clk(clk), .rst(rst), .host(bus.slave),
    .o_qea_start(qea_start), .o_qea_qbit_num(qea_qbit), .i_qea_complete(qea_complete),
    .o_ctx_en(ctx_en), .o_ctx_wea(ctx_wea), .o_ctx_addr(ctx_addr), .o_ctx_data(ctx_data),
    .o_state_ena(state_ena), .o_state_wea(state_wea), .o_state_addra(state_addra),
    .o_state_dina(state_dina), .i_state_dout(state_dout),
    .o_busy(busy), .o_done(done), .o_err(err), .o_cycle_count(cycle_count)
  );

  // State RAM model with one-cycle read latency; load_pat stands in for the accelerator
  logic [W-1:0] mem [0:63];
  logic [W-1:0] pat [0:63];
  logic         load_pat = 1'b0;
  always @(posedge clk) begin
    if (load_pat) begin
      for (int j = 0; j < 64; j++) mem[j] <= pat[j];
    end else if (state_ena) begin
      if (state_wea) mem[state_addra[5:0]] <= state_dina;
      else           state_dout <= mem[state_addra[5:0]];
    end
  end

  int n_total = 0;
  int n_bad   = 0;
  int start_cnt = 0;
  logic [GCAW-1:0] ctx_a_q[$];
  logic [GCDW-1:0] ctx_d_q[$];
  logic [SAW-1:0]  st_a_q[$];
  logic [W-1:0]    st_d_q[$];
  logic [W-1:0]    rd_q[$];

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // RAM write monitor against the queued expectations
  always @(negedge clk) begin
    if (ctx_en) begin
      if (ctx_a_q.size() == 0) begin
        check_val("ctx_extra_write", W'(ctx_en), W'(0));
      end else begin
        check_val("ctx_addr", W'(ctx_addr), W'(ctx_a_q.pop_front()));
        check_val("ctx_data", W'(ctx_data), W'(ctx_d_q.pop_front()));
        check_val("ctx_wea", W'(ctx_wea), W'(1));
      end
    end
    if (state_ena && state_wea) begin
      if (st_a_q.size() == 0) begin
        check_val("state_extra_write", W'(state_wea), W'(0));
      end else begin
        check_val("state_addr", W'(state_addra), W'(st_a_q.pop_front()));
        check_val("state_data", state_dina, st_d_q.pop_front());
      end
    end
    if (qea_start) start_cnt++;
  end

  task automatic bad_cmd(input int ins, input int qbit);
    @(posedge clk); #1;
    bus.i_cmd_valid = 1'b1;
    bus.i_ins_num   = GCAW'(ins);
    bus.i_qbit_num  = MQW'(qbit);
    @(negedge clk);
    check_val("bad_cmd_ready", W'(bus.o_cmd_ready), W'(1));
    @(posedge clk); #1;
    bus.i_cmd_valid = 1'b0;
    @(negedge clk);
    check_val("bad_err_pulse", W'(err), W'(1));
    check_val("bad_busy", W'(busy), W'(0));
    check_val("bad_ready_after", W'(bus.o_cmd_ready), W'(1));
    @(negedge clk);
    check_val("bad_err_end", W'(err), W'(0));
  endtask

  task automatic run_job(input int ins, input int qbit, input int k, input int stall,
                         input bit gaps, input bit abort);
    int n;
    int t;
    logic [GCDW-1:0] words[$];
    logic [GCDW-1:0] w;
    logic [W-1:0]    v;
    n = 1 << (qbit - 2);
    for (int i = 0; i < ins; i++) begin
      w = {$urandom(), $urandom()};
      words.push_back(w);
      ctx_a_q.push_back(GCAW'(i));
      ctx_d_q.push_back(w);
    end
    for (int i = 0; i < n; i++) begin
      v = '0;
      if (i == 0) v[W-1 -: 64] = 64'h4000_0000_0000_0000;
      st_a_q.push_back(SAW'(i));
      st_d_q.push_back(v);
    end
    start_cnt = 0;

    @(posedge clk); #1;
    bus.i_cmd_valid = 1'b1;
    bus.i_ins_num   = GCAW'(ins);
    bus.i_qbit_num  = MQW'(qbit);
    @(negedge clk);
    check_val("cmd_ready", W'(bus.o_cmd_ready), W'(1));
    @(posedge clk); #1;
    bus.i_cmd_valid = 1'b0;

    for (int i = 0; i < ins; i++) begin
      if (gaps) begin
        for (int g = 0; g <= (i % 2); g++) begin
          @(posedge clk); #1;
        end
      end
      bus.i_ctx_valid = 1'b1;
      bus.i_ctx_data  = words[i];
      t = 0;
      @(negedge clk);
      while (!bus.o_ctx_ready && t < 50) begin
        t++;
        @(negedge clk);
      end
      check_val("ctx_ready_wait", W'(bus.o_ctx_ready), W'(1));
      @(posedge clk); #1;
      bus.i_ctx_valid = 1'b0;
    end

    t = 0;
    @(negedge clk);
    while (!qea_start && t < 200) begin
      t++;
      @(negedge clk);
    end
    check_val("start_seen", W'(qea_start), W'(1));
    check_val("qbit_out", W'(qea_qbit), W'(qbit));

    if (abort) begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_val("rst_busy", W'(busy), W'(0));
      check_val("rst_cmd_ready", W'(bus.o_cmd_ready), W'(1));
      check_val("rst_cycles", W'(cycle_count), W'(0));
      check_val("rst_qbit", W'(qea_qbit), W'(0));
      check_val("rst_rd_data", bus.o_rd_data, W'(0));
      check_val("rst_strobes", W'({qea_start, state_ena, ctx_en, bus.o_rd_valid, done, err}), W'(0));
      @(posedge clk); #1 rst = 1'b0;
      repeat (8) @(negedge clk);
      check_val("rst_no_restart", W'(start_cnt), W'(1));
      check_val("rst_idle", W'(busy), W'(0));
      return;
    end

    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 8; j++) v[j*32 +: 32] = $urandom();
      pat[i] = v;
      rd_q.push_back(v);
    end
    load_pat = 1'b1;
    for (int c = 0; c < k; c++) begin
      @(posedge clk); #1;
      load_pat = 1'b0;
      bus.i_cmd_valid = (c == 0);
      if (c == 0) begin
        @(negedge clk);
        check_val("busy_cmd_ready", W'(bus.o_cmd_ready), W'(0));
      end
    end
    qea_complete = 1'b1;
    @(posedge clk); #1;
    qea_complete = 1'b0;

    for (int i = 0; i < n; i++) begin
      t = 0;
      @(negedge clk);
      while (!bus.o_rd_valid && t < 50) begin
        t++;
        @(negedge clk);
      end
      check_val("rd_valid_wait", W'(bus.o_rd_valid), W'(1));
      if (i == stall) begin
        for (int s = 0; s < 5; s++) begin
          check_val("stall_valid", W'(bus.o_rd_valid), W'(1));
          check_val("stall_data", bus.o_rd_data, rd_q[0]);
          @(negedge clk);
        end
      end
      check_val("rd_data", bus.o_rd_data, rd_q.pop_front());
      bus.i_rd_ready = 1'b1;
      @(posedge clk); #1;
      bus.i_rd_ready = 1'b0;
    end

    @(negedge clk);
    check_val("done_pulse", W'(done), W'(1));
    check_val("cycle_count", W'(cycle_count), W'(k));
    check_val("no_extra_rd", W'(bus.o_rd_valid), W'(0));
    @(negedge clk);
    check_val("done_end", W'({done, busy}), W'(0));
    check_val("cycle_hold", W'(cycle_count), W'(k));
    check_val("one_start", W'(start_cnt), W'(1));
    check_val("queues_drained", W'(ctx_a_q.size() + st_a_q.size() + rd_q.size()), W'(0));
  endtask

  initial begin
    rst = 1'b1;
    qea_complete    = 1'b0;
    bus.i_cmd_valid = 1'b0;
    bus.i_ins_num   = '0;
    bus.i_qbit_num  = '0;
    bus.i_ctx_valid = 1'b0;
    bus.i_ctx_data  = '0;
    bus.i_rd_ready  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_ready", W'(bus.o_cmd_ready), W'(1));
    check_val("reset_busy", W'(busy), W'(0));
    check_val("reset_cycles", W'(cycle_count), W'(0));
    @(posedge clk); #1 rst = 1'b0;

    run_job(3, 4, 10, 1, 1'b0, 1'b0);
    bad_cmd(3, 1);
    bad_cmd(0, 4);
    bad_cmd(2, 19);
    run_job(5, 5, 3, -1, 1'b1, 1'b0);
    run_job(1, 2, 2, 0, 1'b0, 1'b0);
    run_job(2, 4, 5, -1, 1'b0, 1'b1);
    run_job(4, 3, 7, 2, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
